ntt_seq_ctrl: RTL

Stage sequencer for the flat D-lane radix-2 NTT datapath (per-lane register, butterfly PE, psi twiddle table). It accepts a coefficient vector through a valid/ready handshake and drives load and stage enables, the stage index, the per-lane subtract mask and the per-lane twiddle addresses for log2(D) stages. It presents the result with a valid/ready output handshake. It replaces the datapath's free-running stage counter, so transforms are start-gated, back-pressurable and deterministic after reset.

---
 rtl/ntt_pkg.sv | 18 +
 rtl/ntt_stage_lut.sv | 29 ++
 rtl/ntt_seq_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT stage sequencers (forward and inverse).
// Provides the 2-bit FSM state encoding and the stage-count helper.
// No ports; import with ntt_pkg::*.
package ntt_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t LOAD = 2'd1;
    localparam state_t RUN  = 2'd2;
    localparam state_t DONE = 2'd3;

    // Number of radix-2 stages for a D-lane transform.
    function automatic int stage_count(input int d);
        return $clog2(d);
    endfunction

endpackage

// File: rtl/ntt_stage_lut.sv
// Stage decode: per-lane subtract mask and psi-table address for one stage.
// Ports: stage_i (stage index) -> sub_mask_o (D bits), tw_addr_o (D lanes of S bits).
// Purely combinational; the caller registers the outputs.
module ntt_stage_lut #(
    parameter int D = 8,
    parameter int S = 3
) (
    input  logic [S-1:0]   stage_i,
    output logic [D-1:0]   sub_mask_o,
    output logic [D*S-1:0] tw_addr_o
);

    always_comb begin
        int stg;
        int addr;
        sub_mask_o = '0;
        tw_addr_o  = '0;
        stg        = int'(stage_i);
        for (int i = 0; i < D; i++) begin
            // Lane i is the upper half of its butterfly pair when the bit
            // selected by the current stage is set.
            sub_mask_o[i] = ((i >> (S - 1 - stg)) & 1) != 0;
            // Twiddle index: group number within the stage plus the stage base.
            addr = (i >> (S - stg)) + (1 << stg);
            tw_addr_o[S*i +: S] = addr[S-1:0];
        end
    end

endmodule

// File: rtl/ntt_seq_ctrl.sv
// Stage sequencer for the flat D-lane radix-2 NTT datapath.
// Ports: in_valid/in_ready/a_in (input vector), load_en/a_load, stage_en/stage/
// sub_mask/tw_addr (datapath control), res_in, out_valid/out_ready/out_data, busy.
module ntt_seq_ctrl
    import ntt_pkg::*;
#(
    parameter  int N = 17,
    parameter  int D = 8,
    localparam int S = stage_count(D)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [D*N-1:0] a_in,
    output logic           load_en,
    output logic [D*N-1:0] a_load,
    output logic           stage_en,
    output logic [S-1:0]   stage,
    output logic [D-1:0]   sub_mask,
    output logic [D*S-1:0] tw_addr,
    input  logic [D*N-1:0] res_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [D*N-1:0] out_data,
    output logic           busy
);

    localparam int LAST_STAGE = S - 1;

    state_t         state_q, state_d;
    logic [S-1:0]   stage_q, stage_d;
    logic           in_ready_q, in_ready_d;
    logic           load_en_q, load_en_d;
    logic [D*N-1:0] a_load_q, a_load_d;
    logic           stage_en_q, stage_en_d;
    logic [D-1:0]   sub_mask_q, sub_mask_d;
    logic [D*S-1:0] tw_addr_q, tw_addr_d;
    logic           out_valid_q, out_valid_d;
    logic [D*N-1:0] out_data_q, out_data_d;
    logic           busy_q, busy_d;

    logic [D-1:0]   lut_mask;
    logic [D*S-1:0] lut_tw;

    // Decode the stage that will be current next cycle so the registered
    // mask/address line up with the registered stage index.
    ntt_stage_lut #(.D(D), .S(S)) u_lut (
        .stage_i    (stage_d),
        .sub_mask_o (lut_mask),
        .tw_addr_o  (lut_tw)
    );

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            stage_q     <= '0;
            in_ready_q  <= 1'b1;
            load_en_q   <= 1'b0;
            a_load_q    <= '0;
            stage_en_q  <= 1'b0;
            sub_mask_q  <= '0;
            tw_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            in_ready_q  <= in_ready_d;
            load_en_q   <= load_en_d;
            a_load_q    <= a_load_d;
            stage_en_q  <= stage_en_d;
            sub_mask_q  <= sub_mask_d;
            tw_addr_q   <= tw_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and stage counter.
    always_comb begin
        state_d = state_q;
        stage_d = '0;
        case (state_q)
            IDLE: if (in_valid) state_d = LOAD;
            LOAD: state_d = RUN;
            RUN: begin
                if (int'(stage_q) == LAST_STAGE) begin
                    state_d = DONE;
                end else begin
                    stage_d = stage_q + 1'b1;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next values, decoded from the next state so every output is a flop.
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        load_en_d   = (state_d == LOAD);
        stage_en_d  = (state_d == RUN);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        sub_mask_d  = (state_d == RUN) ? lut_mask : '0;
        tw_addr_d   = (state_d == RUN) ? lut_tw : '0;
        a_load_d    = a_load_q;
        out_data_d  = out_data_q;
        if (state_q == IDLE && in_valid) begin
            a_load_d = a_in;
        end
        // Result is sampled on the edge that closes the last stage.
        if (state_q == RUN && state_d == DONE) begin
            out_data_d = res_in;
        end
    end

    assign in_ready  = in_ready_q;
    assign load_en   = load_en_q;
    assign a_load    = a_load_q;
    assign stage_en  = stage_en_q;
    assign stage     = stage_q;
    assign sub_mask  = sub_mask_q;
    assign tw_addr   = tw_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule
